// File: rtl/aes_pkg.sv
// Shared AES definitions for the decrypt datapath: block geometry, the
// sequencer state encoding and the InvShiftRows byte permutation.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_NBYTES  = 16;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Byte i is row i%4, column i/4, with byte 0 in the top bits; row r rotates right by r.
    function automatic logic [AES_BLOCK_W-1:0] inv_shift_rows(input logic [AES_BLOCK_W-1:0] s);
        logic [AES_BLOCK_W-1:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[AES_BLOCK_W-1-8*(4*((c+r)%4)+r) -: 8] = s[AES_BLOCK_W-1-8*(4*c+r) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box: purely combinational 256-entry lookup, exact inverse
// of the forward substitution table.
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign y = INV_SBOX[a];

endmodule

// File: rtl/aes_inv_subbytes_seq.sv
// Iterative InvSubBytes + InvShiftRows: NSBOX inverse S-boxes walk the state
// in place over NSTEP cycles, then the permuted result is held until taken.
module aes_inv_subbytes_seq
    import aes_pkg::*;
#(
    parameter int NSBOX = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data
);

    localparam int NSTEP  = AES_NBYTES / NSBOX;
    localparam int CW     = $clog2(NSTEP) + 1;
    localparam int IW     = $clog2(AES_NBYTES);
    localparam int LOG_NS = $clog2(NSBOX);

    if (!(NSBOX == 1 || NSBOX == 2 || NSBOX == 4 || NSBOX == 8 || NSBOX == 16)) begin : g_nsbox_chk
        $error("aes_inv_subbytes_seq: NSBOX must be 1, 2, 4, 8 or 16");
    end

    state_t                        state;
    logic [CW-1:0]                 cnt;
    // Ascending byte index so dreg[i] is byte i, i.e. byte 0 sits in the top bits.
    logic [0:AES_NBYTES-1][7:0]    dreg;
    logic [IW-1:0]                 base;
    logic [NSBOX-1:0][7:0]         sb_in;
    logic [NSBOX-1:0][7:0]         sb_out;

    assign base = IW'(IW'(cnt) << LOG_NS);

    for (genvar k = 0; k < NSBOX; k++) begin : g_lane
        assign sb_in[k] = dreg[base + IW'(k)];
        aes_inv_sbox u_sbox (
            .a (sb_in[k]),
            .y (sb_out[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dreg      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dreg     <= in_data;
                        cnt      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    for (int k = 0; k < NSBOX; k++) begin
                        dreg[base + IW'(k)] <= sb_out[k];
                    end
                    if (cnt == CW'(NSTEP - 1)) begin
                        cnt       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Masked rather than cleared: dreg keeps the last result after hand-off.
    assign out_data = out_valid ? inv_shift_rows(dreg) : '0;

endmodule

// File: tb/tb_aes_inv_subbytes_seq.sv
// Scoreboard bench for aes_inv_subbytes_seq; instances for NSBOX = 1,2,4,8,16
// share stimulus, index 2 (NSBOX=4) is the primary DUT.
module tb_aes_inv_subbytes_seq;

    localparam logic [127:0] T2_IN  = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] T2_EXP = 128'h000d0a0704010e0b0805020f0c090603;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data = '0;
    logic [4:0]   iready;
    logic [4:0]   ovalid;
    logic [127:0] odata [5];

    int passed = 0;
    int total  = 0;
    logic [127:0] sbq [$];
    logic [7:0]   fwd [256];
    logic [7:0]   inv [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        aes_inv_subbytes_seq #(.NSBOX(1 << g)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (iready[g]),
            .in_data   (in_data),
            .out_valid (ovalid[g]),
            .out_ready (out_ready),
            .out_data  (odata[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        logic       hi;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] fsbox(input logic [7:0] v);
        logic [7:0] iv, r;
        iv = '0;
        for (int y = 1; y < 256; y++)
            if (v != 0 && gmul(v, 8'(y)) == 8'h01) iv = 8'(y);
        r = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]} ^ {iv[3:0], iv[7:4]} ^ 8'h63;
        return r;
    endfunction

    function automatic logic [127:0] m_isr(input logic [127:0] s);
        logic [7:0] b [16];
        logic [7:0] o [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        for (int r0 = 0; r0 < 4; r0++)
            for (int c = 0; c < 4; c++) o[((c + r0) & 3) * 4 + r0] = b[c * 4 + r0];
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = o[i];
        return r;
    endfunction

    function automatic logic [127:0] m_sr(input logic [127:0] s);
        logic [7:0] b [16];
        logic [7:0] o [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        for (int r0 = 0; r0 < 4; r0++)
            for (int c = 0; c < 4; c++) o[c * 4 + r0] = b[((c + r0) & 3) * 4 + r0];
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = o[i];
        return r;
    endfunction

    function automatic logic [127:0] m_invsub(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv[s[127-8*i -: 8]];
        return r;
    endfunction

    task automatic send(input logic [127:0] d);
        for (int k = 0; k < 50 && !iready[2]; k++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output bit ok);
        lat = 0; ok = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ovalid[2]) begin lat = k; ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 5; g++) begin
            total++;
            if (ovalid[g] !== 1'b0 || iready[g] !== 1'b1 || odata[g] !== '0)
                $display("FAIL reset[%0d]: got ov=%b rdy=%b data=%h want ov=0 rdy=1 data=0", g, ovalid[g], iready[g], odata[g]);
            else passed++;
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        int lat; bit ok; logic [127:0] exp;
        out_ready = 1'b1;
        sbq.push_back(128'h0);
        send({16{8'h63}});
        wait_out(lat, ok);
        exp = sbq.pop_front();
        total++;
        if (!ok || lat != 4) $display("FAIL zero_latency: got %0d want 4", lat); else passed++;
        total++;
        if (odata[2] !== exp) $display("FAIL zero_data: got %h want %h", odata[2], exp); else passed++;
        @(posedge clk); #1;
        total++;
        if (ovalid[2] !== 1'b0 || iready[2] !== 1'b1)
            $display("FAIL zero_release: got ov=%b rdy=%b want ov=0 rdy=1", ovalid[2], iready[2]);
        else passed++;
    endtask

    task automatic test_known();
        int lat; bit ok; logic [127:0] exp;
        out_ready = 1'b1;
        sbq.push_back(T2_EXP);
        send(T2_IN);
        wait_out(lat, ok);
        exp = sbq.pop_front();
        total++;
        if (!ok) $display("FAIL known_timeout: got no out_valid want out_valid");
        else if (odata[2] !== exp) $display("FAIL known_data: got %h want %h", odata[2], exp);
        else passed++;
    endtask

    task automatic test_backpressure();
        int lat; bit ok; bit bad_v, bad_d, bad_r; logic [127:0] other, exp;
        other = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b0;
        sbq.push_back(T2_EXP);
        send(T2_IN);
        wait_out(lat, ok);
        exp = sbq.pop_front();
        bad_v = !ok; bad_d = 1'b0; bad_r = 1'b0;
        in_valid = 1'b1;
        in_data  = other;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (ovalid[2] !== 1'b1) bad_v = 1'b1;
            if (odata[2] !== exp) bad_d = 1'b1;
            if (iready[2] !== 1'b0) bad_r = 1'b1;
        end
        total++;
        if (bad_v) $display("FAIL bp_hold_valid: got out_valid dropped want held 1"); else passed++;
        total++;
        if (bad_d) $display("FAIL bp_hold_data: got %h want %h", odata[2], exp); else passed++;
        total++;
        if (bad_r) $display("FAIL bp_hold_ready: got in_ready=1 want 0"); else passed++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (ovalid[2] !== 1'b0 || iready[2] !== 1'b1)
            $display("FAIL bp_release: got ov=%b rdy=%b want ov=0 rdy=1", ovalid[2], iready[2]);
        else passed++;
        bad_v = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (ovalid[2] !== 1'b0 || iready[2] !== 1'b1) bad_v = 1'b1;
        end
        total++;
        if (bad_v) $display("FAIL bp_not_queued: got second block processed want idle"); else passed++;
        sbq.push_back(m_isr(m_invsub(other)));
        send(other);
        wait_out(lat, ok);
        exp = sbq.pop_front();
        total++;
        if (!ok || odata[2] !== exp) $display("FAIL bp_second: got %h want %h", odata[2], exp); else passed++;
    endtask

    task automatic test_latency_sweep();
        int lat [5]; logic [127:0] got [5];
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        out_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin lat[g] = 0; got[g] = '0; end
        send(T2_IN);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 5; g++)
                if (ovalid[g] && lat[g] == 0) begin lat[g] = k; got[g] = odata[g]; end
        end
        for (int g = 0; g < 5; g++) begin
            total++;
            if (lat[g] != (16 >> g)) $display("FAIL sweep_lat[nsbox=%0d]: got %0d want %0d", 1 << g, lat[g], 16 >> g);
            else passed++;
            total++;
            if (got[g] !== T2_EXP) $display("FAIL sweep_data[nsbox=%0d]: got %h want %h", 1 << g, got[g], T2_EXP);
            else passed++;
        end
    endtask

    task automatic test_reset_midbusy();
        bit pulse;
        out_ready = 1'b1;
        send(T2_IN);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++;
        if (ovalid[2] !== 1'b0 || iready[2] !== 1'b1 || odata[2] !== '0)
            $display("FAIL midbusy_reset: got ov=%b rdy=%b data=%h want ov=0 rdy=1 data=0", ovalid[2], iready[2], odata[2]);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        pulse = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (ovalid[2]) pulse = 1'b1;
        end
        total++;
        if (pulse) $display("FAIL midbusy_pulse: got out_valid pulse want none"); else passed++;
        test_known();
    endtask

    task automatic test_roundtrip();
        int lat; bit ok; logic [127:0] d, xb, exp, rec;
        logic [7:0] r00, r52, rff;
        r00 = 8'hxx; r52 = 8'hxx; rff = 8'hxx;
        out_ready = 1'b1;
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 16; i++) begin
                xb[127-8*i -: 8] = 8'(16 * b + i);
                d[127-8*i -: 8]  = fwd[16 * b + i];
            end
            sbq.push_back(m_isr(xb));
            send(d);
            wait_out(lat, ok);
            exp = sbq.pop_front();
            rec = m_sr(odata[2]);
            total++;
            if (!ok || odata[2] !== exp) $display("FAIL rt_out[%0d]: got %h want %h", b, odata[2], exp); else passed++;
            total++;
            if (rec !== xb) $display("FAIL rt_recover[%0d]: got %h want %h", b, rec, xb); else passed++;
            if (b == 0)  r00 = rec[127:120];
            if (b == 5)  r52 = rec[127-8*2 -: 8];
            if (b == 15) rff = rec[7:0];
        end
        total++;
        if (r00 !== 8'h00) $display("FAIL rt_63: got %h want 00", r00); else passed++;
        total++;
        if (r52 !== 8'h52) $display("FAIL rt_00: got %h want 52", r52); else passed++;
        total++;
        if (rff !== 8'hff) $display("FAIL rt_16: got %h want ff", rff); else passed++;
    endtask

    initial begin
        for (int x = 0; x < 256; x++) fwd[x] = fsbox(8'(x));
        for (int x = 0; x < 256; x++) inv[fwd[x]] = 8'(x);
        test_reset();
        test_zero();
        test_known();
        test_backpressure();
        test_latency_sweep();
        test_reset_midbusy();
        test_roundtrip();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
